// File: rtl/riser_pkg.sv
// Shared definitions for the CD32 riser CPU-side slave: FSM states and DSACK codes.
package riser_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam logic [1:0] DSACK_8   = 2'b10;
    localparam logic [1:0] DSACK_16  = 2'b01;
    localparam logic [1:0] DSACK_NEG = 2'b11;

    function automatic logic [1:0] ack_code(input logic is_16bit);
        return is_16bit ? DSACK_16 : DSACK_8;
    endfunction

endpackage

// File: rtl/win_decode.sv
// Combinational A[23:16] window matcher; the lowest matching window index wins.
module win_decode #(
    parameter int NUM_WIN = 2
) (
    input  logic [7:0]           addr,
    input  logic [8*NUM_WIN-1:0] win_base,
    output logic                 hit,
    output logic [1:0]           idx
);

    // Walk from the top down so the last (lowest) match overwrites earlier ones.
    always_comb begin
        hit = 1'b0;
        idx = 2'd0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (addr == win_base[8*i +: 8]) begin
                hit = 1'b1;
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/cpu_window_ack.sv
// CPU-side bus slave: decodes NUM_WIN windows, punts hits and holds them in wait
// states until the SPI side is ready or a timeout forces the size acknowledge.
module cpu_window_ack
    import riser_pkg::*;
#(
    parameter int                   NUM_WIN   = 2,
    parameter logic [8*NUM_WIN-1:0] WIN_BASE  = 16'hDCDB,
    parameter logic [NUM_WIN-1:0]   WIN_16BIT = 2'b00,
    parameter int                   WAIT_MIN  = 2,
    parameter int                   TIMEOUT   = 255
) (
    input  logic       CLKCPU_A,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       DS20,
    input  logic       RW,
    input  logic [7:0] A,
    input  logic       PUNT_IN,
    output tri         PUNT_OUT,
    output tri   [1:0] DSACK,
    output logic       REQ,
    output logic [1:0] WIN_SEL,
    output logic       REQ_RW,
    input  logic       RDY,
    output logic       TIMED_OUT,
    output state_t     FSM_STATE
);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       req_n, req_rw_n, timed_out_n;
    logic [1:0] win_sel_n;
    logic       hit;
    logic [1:0] hit_idx;
    logic [3:0] win16_ext;
    logic [1:0] dsack_drv;
    logic       dsack_en;
    logic       unused_ds20;

    assign unused_ds20 = DS20;
    assign win16_ext   = 4'(WIN_16BIT);
    assign FSM_STATE   = state;

    win_decode #(
        .NUM_WIN (NUM_WIN)
    ) u_win_decode (
        .addr     (A),
        .win_base (WIN_BASE),
        .hit      (hit),
        .idx      (hit_idx)
    );

    assign PUNT_OUT = PUNT_IN ? (hit ? 1'b0 : 1'bz) : 1'b0;

    always_ff @(posedge CLKCPU_A or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            REQ       <= 1'b0;
            WIN_SEL   <= 2'd0;
            REQ_RW    <= 1'b1;
            TIMED_OUT <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            REQ       <= req_n;
            WIN_SEL   <= win_sel_n;
            REQ_RW    <= req_rw_n;
            TIMED_OUT <= timed_out_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        req_n       = REQ;
        win_sel_n   = WIN_SEL;
        req_rw_n    = REQ_RW;
        timed_out_n = TIMED_OUT;
        case (state)
            IDLE: begin
                if (!AS20 && PUNT_IN && hit) begin
                    state_n     = WAIT;
                    req_n       = 1'b1;
                    win_sel_n   = hit_idx;
                    req_rw_n    = RW;
                    cnt_n       = 8'd0;
                    timed_out_n = 1'b0;
                end
            end
            WAIT: begin
                if (cnt != 8'hFF) begin
                    cnt_n = cnt + 8'd1;
                end
                // A vanished bus cycle outranks both ready and timeout.
                if (AS20 || !PUNT_IN) begin
                    state_n = REL;
                    req_n   = 1'b0;
                end else if (RDY && (cnt >= 8'(WAIT_MIN))) begin
                    state_n = ACK;
                    req_n   = 1'b0;
                end else if (cnt == 8'(TIMEOUT)) begin
                    state_n     = ACK;
                    req_n       = 1'b0;
                    timed_out_n = 1'b1;
                end
            end
            ACK: begin
                if (AS20) begin
                    state_n = REL;
                end
            end
            REL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Decoded from the registered state so an async reset floats DSACK immediately.
    always_comb begin
        dsack_en  = 1'b0;
        dsack_drv = DSACK_NEG;
        case (state)
            ACK: begin
                dsack_en  = 1'b1;
                dsack_drv = ack_code(win16_ext[WIN_SEL]);
            end
            REL: begin
                dsack_en  = 1'b1;
                dsack_drv = DSACK_NEG;
            end
            default: begin
                dsack_en  = 1'b0;
                dsack_drv = DSACK_NEG;
            end
        endcase
    end

    assign DSACK = dsack_en ? dsack_drv : 2'bzz;

endmodule
